// File: rtl/vchip8_led_sequencer_if.sv
// Requester handshakes, blink enables, Avalon-MM PIO write port and LED shadow
// of the LED sequencer, grouped as one bundle.
interface vchip8_led_sequencer_if;
  logic        req0_valid;
  logic [1:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [1:0]  req1_data;
  logic        req1_ready;
  logic [1:0]  blink_en;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [1:0]  led_shadow;

  // The sequencer owns the PIO, so it takes the master view.
  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, blink_en,
    output req0_ready, req1_ready, avm_address, avm_chipselect,
           avm_write_n, avm_writedata, led_shadow
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, blink_en,
    input  req0_ready, req1_ready, avm_address, avm_chipselect,
           avm_write_n, avm_writedata, led_shadow
  );
endinterface

// File: rtl/vchip8_led_sequencer.sv
// Round-robin LED requester arbiter with per-bit hardware blinking; every
// accepted value or blink refresh becomes a single-cycle PIO write.
module vchip8_led_sequencer #(
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned CNT_W     = 25
) (
  input logic clk,
  input logic reset,
  vchip8_led_sequencer_if.master bus
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;
  logic [1:0]       blink_en_q;
  logic             refresh_pending;
  logic             rr_last;
  logic [1:0]       led_shadow;

  logic             toggle;
  logic             set_refresh;
  logic             clr_refresh;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [1:0]       grant_data;

  assign toggle      = (blink_cnt == CNT_W'(BLINK_DIV - 1));
  assign set_refresh = (toggle && (bus.blink_en != '0)) || (bus.blink_en != blink_en_q);

  always_comb begin
    state_nxt   = state;
    grant0      = 1'b0;
    grant1      = 1'b0;
    clr_refresh = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_pending) begin
          clr_refresh = 1'b1;
          state_nxt   = WRITE;
        end else if (!reset) begin
          // On contention the requester that did not win last time goes.
          if (bus.req0_valid && bus.req1_valid) begin
            grant0 = rr_last;
            grant1 = !rr_last;
          end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
          end
          if (grant0 || grant1) state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = grant0 || grant1;
  assign grant_data = grant1 ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready     = grant0;
  assign bus.req1_ready     = grant1;
  assign bus.led_shadow     = led_shadow;
  assign bus.avm_address    = '0;
  assign bus.avm_chipselect = (state == WRITE);
  assign bus.avm_write_n    = (state != WRITE);
  // Blink is applied at write time, so a late refresh carries the newest shadow.
  assign bus.avm_writedata  = (state == WRITE)
                            ? {30'b0, led_shadow ^ (bus.blink_en & {2{phase}})}
                            : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      blink_cnt       <= '0;
      phase           <= 1'b0;
      blink_en_q      <= '0;
      refresh_pending <= 1'b0;
      rr_last         <= 1'b1;
      led_shadow      <= '0;
    end else begin
      state      <= state_nxt;
      blink_en_q <= bus.blink_en;
      if (toggle) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
      // A new set event in the clearing cycle keeps the refresh pending.
      refresh_pending <= set_refresh || (refresh_pending && !clr_refresh);
      if (accept) begin
        led_shadow <= grant_data;
        rr_last    <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_vchip8_led_sequencer.sv
// Bench for vchip8_led_sequencer: directed vector table, corner sequences and
// random traffic checked cycle by cycle against a behavioural model.
module tb_vchip8_led_sequencer;

  localparam int DIV = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vchip8_led_sequencer_if bus();

  vchip8_led_sequencer #(.BLINK_DIV(DIV), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase is derived from edges since reset.
  bit         m_ok = 1'b0;
  bit         m_busy, m_pend, m_last;
  logic [1:0] m_shadow, m_prev_en;
  int         m_k;

  logic       s_rst, s_v0, s_v1;
  logic [1:0] s_d0, s_d1, s_en;
  bit         e_r0, e_r1;
  logic [1:0] wr_q[$];
  int         wr_cnt;

  typedef struct {
    bit rst; bit v0; logic [1:0] d0; bit v1; logic [1:0] d1; logic [1:0] en;
    bit r0; bit r1; bit cs; logic [1:0] wd; logic [1:0] sh;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(bit rst, bit v0, logic [1:0] d0, bit v1, logic [1:0] d1,
                              logic [1:0] en, bit r0, bit r1, bit cs,
                              logic [1:0] wd, logic [1:0] sh);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.en = en;
    v.r0 = r0; v.r1 = r1; v.cs = cs; v.wd = wd; v.sh = sh;
    return v;
  endfunction

  function automatic logic [39:0] dut_vec();
    return {bus.req0_ready, bus.req1_ready, bus.avm_chipselect, bus.avm_write_n,
            bus.avm_address, bus.avm_writedata, bus.led_shadow};
  endfunction

  function automatic logic [39:0] model_exp();
    bit          ph = ((m_k / DIV) % 2) == 1;
    bit          r0 = 1'b0;
    bit          r1 = 1'b0;
    bit          cs = 1'b0;
    logic [31:0] wd = '0;
    if (m_busy) begin
      cs = 1'b1;
      wd = {30'b0, m_shadow ^ (s_en & {2{ph}})};
    end
    if (!s_rst && !m_busy && !m_pend) begin
      if (s_v0 && s_v1) begin
        if (m_last) r0 = 1'b1; else r1 = 1'b1;
      end else begin
        r0 = s_v0;
        r1 = s_v1;
      end
    end
    return {r0, r1, cs, ~cs, 2'b00, wd, m_shadow};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic sample();
    logic [39:0] e;
    @(negedge clk);
    s_rst = reset; s_v0 = bus.req0_valid; s_v1 = bus.req1_valid;
    s_d0 = bus.req0_data; s_d1 = bus.req1_data; s_en = bus.blink_en;
    e_r0 = 1'b0; e_r1 = 1'b0;
    if (m_ok) begin
      e = model_exp();
      e_r0 = e[39];
      e_r1 = e[38];
      check("model", dut_vec(), e);
    end
    if (bus.avm_chipselect === 1'b1) begin
      wr_q.push_back(bus.avm_writedata[1:0]);
      wr_cnt++;
    end
  endtask

  task automatic advance();
    bit tog, set;
    @(posedge clk);
    if (s_rst) begin
      m_ok = 1'b1; m_busy = 1'b0; m_pend = 1'b0; m_last = 1'b1;
      m_shadow = '0; m_prev_en = '0; m_k = 0;
    end else if (m_ok) begin
      tog = ((m_k + 1) % DIV) == 0;
      set = (tog && s_en != 2'b00) || (s_en != m_prev_en);
      if (m_busy) begin
        m_busy = 1'b0;
        m_pend = m_pend | set;
      end else if (m_pend) begin
        m_busy = 1'b1;
        m_pend = set;
      end else if (e_r0 || e_r1) begin
        m_shadow = e_r0 ? s_d0 : s_d1;
        m_last   = e_r1;
        m_busy   = 1'b1;
        m_pend   = m_pend | set;
      end else begin
        m_pend = m_pend | set;
      end
      m_prev_en = s_en;
      m_k++;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive(input bit rst, input bit v0, input logic [1:0] d0,
                       input bit v1, input logic [1:0] d1, input logic [1:0] en);
    reset = rst;
    bus.req0_valid = v0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_data = d1;
    bus.blink_en = en;
  endtask

  initial begin
    bit   h0, h1;
    logic [39:0] exp;

    tbl[0]  = mk(0, 1, 2, 0, 0, 0,  1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 2);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    tbl[5]  = mk(0, 1, 1, 1, 2, 0,  1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 2, 0,  0, 0, 1, 1, 1);
    tbl[7]  = mk(0, 1, 1, 1, 2, 0,  0, 1, 0, 0, 1);
    tbl[8]  = mk(0, 1, 1, 1, 2, 0,  0, 0, 1, 2, 2);
    tbl[9]  = mk(0, 1, 1, 1, 2, 0,  1, 0, 0, 0, 2);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, 3, 0, 0, 1,  0, 0, 0, 0, 1);
    tbl[14] = mk(0, 1, 3, 0, 0, 1,  0, 0, 1, 0, 1);
    tbl[15] = mk(0, 1, 3, 0, 0, 1,  1, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 2, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3);

    wr_cnt = 0;
    drive(1, 0, 0, 0, 0, 0);
    #1;
    step();
    step();

    // Directed table: single accept, reset, round robin, refresh/request collision.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].en);
      sample();
      exp = {tbl[i].r0, tbl[i].r1, tbl[i].cs, ~tbl[i].cs, 2'b00, 30'b0, tbl[i].wd, tbl[i].sh};
      check($sformatf("tbl_row%0d", i), dut_vec(), exp);
      advance();
    end

    // Blink with both bits enabled on shadow 01.
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    wr_q.delete();
    drive(0, 0, 0, 0, 0, 2'b11);
    for (int i = 0; i < 20; i++) step();
    if (wr_q.size() < 3) check("blink_write_count", 40'(wr_q.size()), 40'd3);
    else begin
      check("blink_w0", 40'(wr_q[0]), 40'd1);
      check("blink_w1", 40'(wr_q[1]), 40'd2);
      check("blink_w2", 40'(wr_q[2]), 40'd1);
    end

    // Blink disabled: no writes, yet phase keeps running.
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 2, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    wr_cnt = 0;
    for (int i = 0; i < 40; i++) step();
    check("no_blink_writes", 40'(wr_cnt), 40'd0);
    for (int i = 0; i < 32 && !(((m_k / DIV) % 2) == 1 && (m_k % DIV) <= 4); i++) step();
    wr_q.delete();
    drive(0, 0, 0, 0, 0, 2'b01);
    for (int i = 0; i < 3; i++) step();
    if (wr_q.size() < 1) check("en_change_write_count", 40'(wr_q.size()), 40'd1);
    else check("en_change_phase1_data", 40'(wr_q[0]), 40'd3);

    // Reset during the write cycle.
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 2, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("write_before_reset", 40'(bus.avm_chipselect), 40'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    sample();
    check("after_reset_cs_shadow", {37'b0, bus.avm_chipselect, bus.led_shadow}, 40'd0);
    advance();
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) step();
    check("no_replay_after_reset", 40'(wr_cnt), 40'd0);

    // Random traffic against the model; requesters hold until accepted.
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 119) == 0) reset = 1'b1;
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1; bus.req0_data = 2'($urandom);
      end
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1; bus.req1_data = 2'($urandom);
      end
      if ($urandom_range(0, 24) == 0) bus.blink_en = 2'($urandom);
      sample();
      h0 = e_r0;
      h1 = e_r1;
      advance();
      if (h0) bus.req0_valid = 1'b0;
      if (h1) bus.req1_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
